frame_buffer_rx: RTL

FRAME_BUFFER_RX -- requirements
Module: frame_buffer_rx

---
 rtl/frame_buffer_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/frame_buffer_rx.sv
// frame_buffer_rx: frame receive buffer; in: axiiv/axiid (N-bit chunks, MSB-first) + axiierr at frame end; out: axiov/axiod/axiolast stream with axioready, status frame_len/frames_pending/drop_count
module frame_buffer_rx #(
  parameter int N = 2,
  parameter int W = 16,
  parameter int DEPTH = 256,
  parameter int SLOTS = 4,
  parameter int TRIM_WORDS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   axiiv,
  input  logic [N-1:0]           axiid,
  input  logic                   axiierr,
  input  logic                   axioready,
  output logic                   axiov,
  output logic [W-1:0]           axiod,
  output logic                   axiolast,
  output logic [7:0]             frame_len,
  output logic [$clog2(SLOTS):0] frames_pending,
  output logic [7:0]             drop_count
);
  localparam int CPW = W / N;
  localparam int CW = CPW > 1 ? $clog2(CPW) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SLOTS);
  localparam int LW = AW + 1 > 8 ? AW + 1 : 8;
  typedef enum logic [1:0] {IDLE, FETCH, STREAM, SKIP} state_t;
  state_t state, state_n;
  logic [W-1:0] mem [DEPTH];
  logic [LW-1:0] dq [SLOTS];
  logic [W-1:0] wbuf, cw, rd_data;
  logic [CW-1:0] cnt;
  logic skip, prev_act, ovf;
  logic [AW:0] wptr, fstart, rstart, rptr, used, rnext, wptr_n;
  logic [LW-1:0] len, len_f, rem, head_len;
  logic [SW-1:0] head, tail;
  logic act, fend, wr_word, wr_part, we, ovf_f, commit, load, pop;
  always_comb begin
    act = axiiv && !skip;
    fend = prev_act && !axiiv;
    cw = cnt == '0 ? '0 : wbuf;
    for (int k = 0; k < CPW; k++)
      if (cnt == CW'(k)) cw[W-1-k*N -: N] = axiid;
    wr_word = act && cnt == CW'(CPW - 1);
    wr_part = fend && cnt != '0;
    used = wptr - rstart;
    we = (wr_word || wr_part) && !ovf && !used[AW];
    ovf_f = ovf || ((wr_word || wr_part) && used[AW]);
    wptr_n = wptr + (AW+1)'(we);
    len_f = len + LW'(we);
    commit = fend && !axiierr && !ovf_f && len_f > LW'(TRIM_WORDS) && frames_pending != (SW+1)'(SLOTS);
  end
  always_ff @(posedge clk) begin
    if (we) mem[wptr[AW-1:0]] <= wr_part ? wbuf : cw;
    rd_data <= mem[rnext[AW-1:0]];
  end
  always_ff @(posedge clk)
    if (commit) dq[tail] <= len_f;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      wbuf <= '0;
      skip <= 1'b1;
      prev_act <= 1'b0;
      ovf <= 1'b0;
      wptr <= '0;
      fstart <= '0;
      len <= '0;
      tail <= '0;
      drop_count <= '0;
    end else begin
      skip <= skip && axiiv;
      prev_act <= act;
      if (act) begin
        cnt <= wr_word ? '0 : cnt + CW'(1);
        wbuf <= cw;
      end
      wptr <= wptr_n;
      len <= len_f;
      ovf <= ovf_f;
      if (fend) begin
        cnt <= '0;
        len <= '0;
        ovf <= 1'b0;
        if (commit) begin
          fstart <= wptr_n;
          tail <= tail + SW'(1);
        end else begin
          wptr <= fstart;
          drop_count <= drop_count + 8'(~&drop_count);
        end
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      frames_pending <= '0;
      head <= '0;
    end else begin
      frames_pending <= frames_pending + (SW+1)'(commit) - (SW+1)'(pop);
      if (pop) head <= head + SW'(1);
    end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    load = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE: state_n = |frames_pending ? FETCH : IDLE;
      FETCH: state_n = STREAM;
      STREAM: begin
        load = (!axiov || axioready) && |rem;
        state_n = (!axiov || axioready) && rem == '0 ? SKIP : STREAM;
      end
      default: begin
        pop = 1'b1;
        state_n = IDLE;
      end
    endcase
    rnext = load ? rptr + (AW+1)'(1) : rptr;
    head_len = dq[head];
    frame_len = |frames_pending ? head_len[7:0] : 8'd0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      rptr <= '0;
      rstart <= '0;
      rem <= '0;
      axiov <= 1'b0;
      axiolast <= 1'b0;
      axiod <= '0;
    end else begin
      if (state == IDLE) rem <= head_len - LW'(TRIM_WORDS);
      if (load) begin
        axiod <= rd_data;
        axiov <= 1'b1;
        axiolast <= rem == LW'(1);
        rptr <= rnext;
        rem <= rem - LW'(1);
      end else if (axioready) begin
        axiov <= 1'b0;
        axiolast <= 1'b0;
      end
      if (pop) begin
        rstart <= rstart + head_len[AW:0];
        rptr <= rstart + head_len[AW:0];
      end
    end
endmodule
